// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between the register-file read side and writeback
interface alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alufs;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu;
  logic [3:0]       flags;
  modport master (output in_valid, alufs, a, b, out_ready, input in_ready, out_valid, alu, flags);
  modport slave  (input in_valid, alufs, a, b, out_ready, output in_ready, out_valid, alu, flags);
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: single-stage registered ALU with NZCV flags and valid/ready on both sides
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clear,
  alu_pipe_if.slave bus
);
  logic             r_valid;
  logic [WIDTH-1:0] r_alu;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic             w_arith;
  logic             w_take;
  always_comb begin
    w_opa   = bus.alufs[2:1] == 2'b00 ? '0 : bus.a;
    w_opb   = (bus.alufs == 3'b011 || bus.alufs == 3'b101) ? ~bus.b : bus.b;
    w_cin   = (bus.alufs == 3'b001 || bus.alufs == 3'b011) ? 1'b1 :
              bus.alufs[2:1] == 2'b10 ? r_flags[1] : 1'b0;
    w_sum   = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    w_arith = bus.alufs[2:1] != 2'b11;
    w_res   = bus.alufs == 3'b110 ? (bus.a & bus.b) :
              bus.alufs == 3'b111 ? (bus.a ^ bus.b) : w_sum[WIDTH-1:0];
  end
  assign bus.in_ready  = !clear && (!r_valid || bus.out_ready);
  assign w_take        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_valid;
  assign bus.alu       = r_alu;
  assign bus.flags     = r_flags;
  // Flags feed back into w_cin, so an adc/sbc accepted the very next cycle chains without a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_flags <= 4'b0000;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_flags <= 4'b0000;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_alu   <= w_res;
      r_flags <= {w_res[WIDTH-1], w_res == '0, w_arith & w_sum[WIDTH],
                  w_arith & (w_opa[WIDTH-1] == w_opb[WIDTH-1]) & (w_res[WIDTH-1] != w_opa[WIDTH-1])};
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH 16 plus a directed WIDTH 8 instance
module tb_alu_pipe;
  logic clk = 0;
  logic reset_n = 1;
  logic clear = 0;
  logic clear8 = 0;
  int total = 0;
  int bad = 0;
  int acc = 0;
  int n0;
  logic [19:0] q[$];
  logic mc = 0;
  logic m_rdy;
  logic [19:0] m_e;
  alu_pipe_if #(16) bus ();
  alu_pipe_if #(8) bus8 ();
  alu_pipe #(.WIDTH(16)) dut (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus.slave));
  alu_pipe #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .clear(clear8), .bus(bus8.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] model(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y, input logic c);
    int ux, uy, sx, sy, u, s, ci;
    logic cf, vf;
    logic [15:0] r;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    ci = int'(c);
    u = 0; s = 0; cf = 0; vf = 0;
    case (f)
      3'd0: begin u = uy; s = sy; end
      3'd1: begin u = uy + 1; s = sy + 1; end
      3'd2: begin u = ux + uy; s = sx + sy; end
      3'd3: begin u = ux - uy; s = sx - sy; end
      3'd4: begin u = ux + uy + ci; s = sx + sy + ci; end
      3'd5: begin u = ux - uy - 1 + ci; s = sx - sy - 1 + ci; end
      default: ;
    endcase
    r = f == 3'd6 ? (x & y) : f == 3'd7 ? (x ^ y) : u[15:0];
    if (f == 3'd3 || f == 3'd5) cf = u >= 0;
    else if (f < 3'd6) cf = u > 65535;
    if (f < 3'd6) vf = s > 32767 || s < -32768;
    return {r, r[15], r == 16'h0, cf, vf};
  endfunction
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mc = 0;
    end else begin
      m_rdy = !clear && (q.size() == 0 || bus.out_ready);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      if (q.size() != 0 && bus.out_ready) chk("result", {bus.alu, bus.flags}, q[0]);
      if (q.size() != 0 && (bus.out_ready || clear)) void'(q.pop_front());
      if (clear) mc = 0;
      else if (bus.in_valid && m_rdy) begin
        m_e = model(bus.alufs, bus.a, bus.b, mc);
        q.push_back(m_e);
        mc = m_e[1];
        acc++;
      end
    end
  end
  task automatic send(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
    bus.in_valid = 1; bus.alufs = f; bus.a = x; bus.b = y;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask
  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 0; bus.alufs = 0; bus.a = 0; bus.b = 0; bus.out_ready = 1;
    bus8.in_valid = 0; bus8.alufs = 0; bus8.a = 0; bus8.b = 0; bus8.out_ready = 1;
    #1 reset_n = 0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu", 32'(bus.alu), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #1 reset_n = 1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    bus8.in_valid = 1; bus8.alufs = 3'b010; bus8.a = 8'h7F; bus8.b = 8'h01;
    @(posedge clk); #1;
    chk("w8_ovf", {bus8.alu, bus8.flags}, {8'h80, 4'b1001});
    bus8.a = 8'hFF;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    chk("w8_wrap", {bus8.alu, bus8.flags}, {8'h00, 4'b0110});
    send(3'b010, 16'hFFFF, 16'h0001);
    chk("add_wrap", {bus.alu, bus.flags}, {16'h0000, 4'b0110});
    send(3'b100, 16'h0000, 16'h0000);
    chk("adc_c", {bus.alu, bus.flags}, {16'h0001, 4'b0000});
    send(3'b011, 16'h8000, 16'h0001);
    chk("sub_ovf", {bus.alu, bus.flags}, {16'h7FFF, 4'b0011});
    send(3'b011, 16'h0001, 16'h0002);
    chk("sub_neg", {bus.alu, bus.flags}, {16'hFFFF, 4'b1000});
    send(3'b011, 16'h0000, 16'h0001);
    chk("sbc_lo", {bus.alu, bus.flags}, {16'hFFFF, 4'b1000});
    send(3'b101, 16'h0001, 16'h0000);
    chk("sbc_hi", {bus.alu, bus.flags}, {16'h0000, 4'b0110});
    idle(1);
    bus.out_ready = 0;
    send(3'b010, 16'h0003, 16'h0004);
    chk("bp_first", {bus.alu, bus.flags}, {16'h0007, 4'b0000});
    bus.in_valid = 1; bus.alufs = 3'b111; bus.a = 16'hAAAA; bus.b = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      chk("stall_rdy", 32'(bus.in_ready), 32'd0);
      chk("stall_hold", {bus.out_valid, bus.alu, bus.flags}, {1'b1, 16'h0007, 4'b0000});
    end
    @(posedge clk); #1 bus.out_ready = 1;
    @(negedge clk);
    chk("unstall_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("xor", {bus.alu, bus.flags}, {16'hFFFF, 4'b1000});
    n0 = acc;
    bus.alufs = 3'b010; bus.a = 16'hFFFF; bus.b = 16'h0001;
    @(posedge clk); #1;
    bus.alufs = 3'b100; bus.a = 16'h0000; bus.b = 16'h0000;
    @(posedge clk); #1;
    bus.alufs = 3'b101; bus.a = 16'h0005; bus.b = 16'h0003;
    @(posedge clk); #1;
    bus.alufs = 3'b001; bus.a = 16'h1234; bus.b = 16'h7FFF;
    @(posedge clk); #1;
    chk("stream_cnt", 32'(acc - n0), 32'd4);
    chk("stream_last", {bus.alu, bus.flags}, {16'h8000, 4'b1001});
    bus.out_ready = 0;
    clear = 1; bus.alufs = 3'b010; bus.a = 16'h0001; bus.b = 16'h0001;
    @(negedge clk);
    chk("clr_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 0; bus.in_valid = 0;
    chk("clr_state", {bus.out_valid, bus.alu, bus.flags}, {1'b0, 16'h8000, 4'b0000});
    bus.out_ready = 1;
    send(3'b110, 16'hF0F0, 16'h0FF0);
    chk("and", {bus.alu, bus.flags}, {16'h00F0, 4'b0000});
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.alufs = 3'($urandom_range(0, 7));
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 15) == 0;
      @(posedge clk); #1;
    end
    clear = 0; bus.out_ready = 1;
    idle(2);
    bus.out_ready = 0;
    send(3'b010, 16'h1234, 16'h0001);
    chk("pre_rst", {bus.out_valid, bus.alu, bus.flags}, {1'b1, 16'h1235, 4'b0000});
    @(negedge clk); #2 reset_n = 0;
    #1;
    chk("mid_rst", {bus.out_valid, bus.alu, bus.flags}, 32'd0);
    @(posedge clk); #1 reset_n = 1;
    chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1;
    send(3'b100, 16'h0000, 16'h0000);
    chk("post_rst_c", {bus.alu, bus.flags}, {16'h0000, 4'b0100});
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
